// File: rtl/dmem_responder.sv
// Data-memory responder with a fixed access latency and a held response,
// standing in for the single-cycle data RAM so that stall paths see a slow memory.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [31:0]   r_addr, r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept, w_access, w_err;
  logic [AW-1:0] w_idx;

  // Any set bit above the index range means the word lies past the array.
  assign w_idx = r_addr[AW+1:2];
  assign w_err = (r_addr[1:0] != 2'b00) || (|(r_addr[31:2] >> AW));

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    w_accept  = 1'b0;
    w_access  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access = 1'b1;
          w_next   = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_we) ? 32'd0 : r_mem[w_idx];
      end
    end
  end

  // Array has no reset; a reset pending in WAIT suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && w_access && r_we && !w_err) begin
      for (int i = 0; i < 4; i++)
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
endmodule
